// File: rtl/load_align_sequencer.sv
// Splits each memory-stage load into one or two aligned beat reads and realigns
// the result so the requested bytes start at lane 0 for the writeback truncator.
`ifndef XLEN
`define XLEN 32
`endif

package HighLevelControl;
    typedef enum logic [2:0] {
        BYTE,
        HALF_WORD,
        WORD,
        NO_TRUNC,
        BYTE_UNSIGNED,
        HALF_WORD_UNSIGNED,
        WORD_UNSIGNED
    } truncType;
endpackage

module load_align_sequencer
    import HighLevelControl::*;
#(
    parameter int unsigned XLEN  = `XLEN,
    parameter int unsigned BYTES = XLEN / 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       LoadValid,
    input  logic [XLEN-1:0]            LoadAddr,
    input  truncType                   LoadType,
    input  logic                       Flush,
    output logic                       MemReq,
    output logic [XLEN-1:0]            MemAddr,
    input  logic                       MemGrant,
    input  logic                       MemRespValid,
    input  logic [XLEN-1:0]            MemRespData,
    output logic                       Stall,
    output logic                       LoadDone,
    output logic [XLEN-1:0]            TruncData,
    output truncType                   TruncType,
    output logic [$clog2(BYTES)-1:0]   TruncSrc
);

    localparam int unsigned OW = $clog2(BYTES);
    localparam int unsigned SW = OW + 1;

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE, DRAIN} state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] base_q;
    logic [OW-1:0]   off_q;
    logic            split_q;
    truncType        type_q;
    logic [XLEN-1:0] beat0_q;
    logic            mem_req_q;
    logic [XLEN-1:0] mem_addr_q;
    logic            load_done_q;
    logic [XLEN-1:0] trunc_data_q;

    logic            accept;
    logic [SW-1:0]   size_c;
    logic            split_c;
    logic [XLEN-1:0] base_c;
    logic [2*XLEN-1:0] pair_c;
    logic [XLEN-1:0] merged_c;

    assign accept = (state == IDLE) && LoadValid && !Flush;
    assign base_c = {LoadAddr[XLEN-1:OW], OW'(0)};

    // Access size and boundary-crossing test, one bit wider than the offset so the sum cannot overflow
    always_comb begin
        size_c = SW'(BYTES);
        case (LoadType)
            BYTE, BYTE_UNSIGNED:           size_c = SW'(1);
            HALF_WORD, HALF_WORD_UNSIGNED: size_c = SW'(2);
            WORD, WORD_UNSIGNED:           size_c = SW'(4);
            default:                       size_c = SW'(BYTES);
        endcase
        split_c = (SW'(LoadAddr[OW-1:0]) + size_c) > SW'(BYTES);
    end

    // Lane realignment of the beat(s) arriving this cycle; upper beat is zero unless split
    always_comb begin
        pair_c   = (state == WAIT1) ? {MemRespData, beat0_q} : {XLEN'(0), MemRespData};
        merged_c = XLEN'(pair_c >> {off_q, 3'b000});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (LoadValid && !Flush) state_n = REQ0;
            REQ0: begin
                if (Flush)         state_n = MemGrant ? DRAIN : IDLE;
                else if (MemGrant) state_n = WAIT0;
            end
            WAIT0: begin
                if (MemRespValid)  state_n = Flush ? IDLE : (split_q ? REQ1 : DONE);
                else if (Flush)    state_n = DRAIN;
            end
            REQ1: begin
                if (Flush)         state_n = MemGrant ? DRAIN : IDLE;
                else if (MemGrant) state_n = WAIT1;
            end
            WAIT1: begin
                if (MemRespValid)  state_n = Flush ? IDLE : DONE;
                else if (Flush)    state_n = DRAIN;
            end
            DONE:  state_n = IDLE;
            DRAIN: if (MemRespValid) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Request capture, beat storage and registered outputs, all keyed off the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q       <= '0;
            off_q        <= '0;
            split_q      <= 1'b0;
            type_q       <= NO_TRUNC;
            beat0_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            load_done_q  <= 1'b0;
            trunc_data_q <= '0;
        end else begin
            if (accept) begin
                base_q     <= base_c;
                off_q      <= LoadAddr[OW-1:0];
                split_q    <= split_c;
                type_q     <= LoadType;
                mem_addr_q <= base_c;
            end else if (state == WAIT0 && state_n == REQ1) begin
                mem_addr_q <= base_q + XLEN'(BYTES);
            end
            if (state == WAIT0 && MemRespValid) beat0_q <= MemRespData;
            mem_req_q   <= (state_n == REQ0) || (state_n == REQ1);
            load_done_q <= (state_n == DONE);
            if (state_n == DONE) trunc_data_q <= merged_c;
        end
    end

    assign MemReq    = mem_req_q;
    assign MemAddr   = mem_addr_q;
    assign LoadDone  = load_done_q;
    assign TruncData = trunc_data_q;
    assign TruncType = type_q;
    assign TruncSrc  = '0;
    assign Stall     = !((state == IDLE) || (state == DONE)) || accept;

endmodule
